// File: rtl/pbsbf_interp.sv
// pbsbf_interp: CH-channel cubic B-spline interpolator emitting L = 2^PHASE_W points per input frame.
// Define PBSBF_SIGNED_EN for two's-complement data; the default build is unsigned.
module pbsbf_interp #(
    parameter int DIN_W     = 8,
    parameter int CH        = 2,
    parameter int PHASE_W   = 1,
    parameter int COEF_F    = 7,
    parameter int CLK_FREQ  = 100_000_000,
    parameter int TICK_RATE = 10_000
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [CH*DIN_W-1:0] din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic [CH*DIN_W-1:0] dout,
    output logic                dout_valid,
    output logic [PHASE_W-1:0]  phase,
    output logic                underrun
);
    localparam int L        = 1 << PHASE_W;
    localparam int TICK_DIV = CLK_FREQ / TICK_RATE;
    localparam int CNT_W    = $clog2(TICK_DIV);
    localparam int WGT_W    = COEF_F + 1;
    localparam int PROD_W   = DIN_W + COEF_F + 1;
    localparam int SUM_W    = DIN_W + COEF_F + 3;
    localparam int HALF     = 1 << (COEF_F - 1);

`ifdef PBSBF_SIGNED_EN
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [SUM_W-1:0]  sum_t;
`else
    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [SUM_W-1:0]  sum_t;
`endif
    typedef logic [DIN_W-1:0] data_t;

    function automatic longint coef(input longint kk, input longint idx);
        longint ll, bb, dd, half, one, w0, w2, w3, res;
        ll   = longint'(L);
        bb   = ll - kk;
        dd   = 6 * ll * ll * ll;
        half = dd / 2;
        one  = longint'(1) << COEF_F;
        w0   = (bb * bb * bb * one + half) / dd;
        w3   = (kk * kk * kk * one + half) / dd;
        w2   = ((-3 * kk * kk * kk + 3 * kk * kk * ll + 3 * kk * ll * ll + ll * ll * ll) * one + half) / dd;
        case (idx)
            0:       res = w0;
            1:       res = one - w0 - w2 - w3;
            2:       res = w2;
            default: res = w3;
        endcase
        return res;
    endfunction

    function automatic prod_t mul(input data_t h, input logic [WGT_W-1:0] w);
`ifdef PBSBF_SIGNED_EN
        return prod_t'($signed(h)) * prod_t'(w);
`else
        return prod_t'(h) * prod_t'(w);
`endif
    endfunction

    // w1 absorbs the rounding residue so every phase sums to exactly 2^COEF_F (exact DC gain).
    logic [WGT_W-1:0] wtab [L][4];
    for (genvar p = 0; p < L; p++) begin : g_phase
        for (genvar i = 0; i < 4; i++) begin : g_tap
            localparam logic [WGT_W-1:0] W = WGT_W'(coef(longint'(p), longint'(i)));
            assign wtab[p][i] = W;
        end
    end

    logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [PHASE_W-1:0]  k_q, k_d;
    logic [CH*DIN_W-1:0] pend_q, pend_d;
    logic                pend_full_q, pend_full_d;
    data_t               hist_q [CH][4];
    data_t               hist_d [CH][4];
    prod_t               prod_q [CH][4];
    prod_t               prod_d [CH][4];
    logic                s1_valid_q, s1_valid_d;
    logic [PHASE_W-1:0]  s1_phase_q, s1_phase_d;
    logic [CH*DIN_W-1:0] dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic                underrun_q, underrun_d;
    logic                tick, wrap;
    sum_t                sum_v, rnd_v;

    always_comb begin
        tick         = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
        wrap         = tick && (k_q == PHASE_W'(L - 1));
        tick_cnt_d   = tick ? '0 : tick_cnt_q + CNT_W'(1);
        k_d          = tick ? k_q + PHASE_W'(1) : k_q;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        hist_d       = hist_q;
        underrun_d   = 1'b0;
        prod_d       = prod_q;
        s1_valid_d   = tick;
        s1_phase_d   = tick ? k_q : s1_phase_q;
        dout_d       = dout_q;
        dout_valid_d = s1_valid_q;
        phase_d      = s1_valid_q ? s1_phase_q : phase_q;
        sum_v        = '0;
        rnd_v        = '0;

        // Shift uses pend_q from before this edge, so a frame accepted on the wrap waits a full cycle of phases.
        if (wrap) begin
            underrun_d  = !pend_full_q;
            pend_full_d = 1'b0;
            for (int unsigned c = 0; c < CH; c++) begin
                hist_d[c][0] = hist_q[c][1];
                hist_d[c][1] = hist_q[c][2];
                hist_d[c][2] = hist_q[c][3];
                hist_d[c][3] = pend_full_q ? pend_q[c*DIN_W +: DIN_W] : hist_q[c][3];
            end
        end
        if (din_valid && !pend_full_q) begin
            pend_d      = din;
            pend_full_d = 1'b1;
        end

        if (tick) begin
            for (int unsigned c = 0; c < CH; c++) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    prod_d[c][i] = mul(hist_q[c][i], wtab[k_q][i]);
                end
            end
        end

        if (s1_valid_q) begin
            for (int unsigned c = 0; c < CH; c++) begin
                sum_v = '0;
                for (int unsigned i = 0; i < 4; i++) begin
                    sum_v = sum_v + sum_t'(prod_q[c][i]);
                end
                rnd_v = sum_v + sum_t'(HALF);
                dout_d[c*DIN_W +: DIN_W] = DIN_W'(rnd_v >>> COEF_F);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            tick_cnt_q   <= '0;
            k_q          <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_phase_q   <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            phase_q      <= '0;
            underrun_q   <= 1'b0;
            for (int unsigned c = 0; c < CH; c++) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    hist_q[c][i] <= '0;
                    prod_q[c][i] <= '0;
                end
            end
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            k_q          <= k_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            hist_q       <= hist_d;
            prod_q       <= prod_d;
            s1_valid_q   <= s1_valid_d;
            s1_phase_q   <= s1_phase_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            phase_q      <= phase_d;
            underrun_q   <= underrun_d;
        end
    end

    assign din_ready  = !pend_full_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign phase      = phase_q;
    assign underrun   = underrun_q;

endmodule
